// File: rtl/decoder_r_insn.sv
// Control decoder for RV32I R-type (OP opcode) instructions in the single-cycle CPU.
// Validates the encoding, slices register fields, gates the register-file write clock.
module decoder_r_insn (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSN,
  output logic        sub_sra,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        rd_clk,
  output logic        mem_clk,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [2:0]  alu_func,
  output logic        valid,
  output logic        illegal_q
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SRLSRA = 3'b101;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       is_op;
  logic       alt_ok;

  assign opcode   = INSN[6:0];
  assign funct7   = INSN[31:25];
  assign rs1_addr = INSN[19:15];
  assign rs2_addr = INSN[24:20];
  assign rd_addr  = INSN[11:7];
  assign alu_func = INSN[14:12];

  // funct7 = 0100000 is only meaningful for SUB and SRA; everything else is illegal.
  assign is_op  = (opcode == OPC_OP);
  assign alt_ok = (funct7 == F7_ALT) && ((alu_func == F3_ADDSUB) || (alu_func == F3_SRLSRA));
  assign valid  = is_op && ((funct7 == F7_BASE) || alt_ok);

  assign sub_sra     = valid & INSN[30];
  assign addr_sel    = 1'b0;
  assign pc_next_sel = 1'b0;
  assign pc_alu_sel  = 1'b0;
  assign mem_clk     = 1'b0;

  // Upstream only changes INSN while CLK is low, so this AND gate cannot glitch.
  assign rd_clk = CLK & RST_N & valid & (rd_addr != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async clear makes reset take effect mid-cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      illegal_q <= 1'b0;
    end else if (is_op && !valid) begin
      illegal_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_r_insn.sv
// Self-checking bench for decoder_r_insn: a table of directed R-type vectors plus
// hand-written reset and sticky-flag sequences.
module tb_decoder_r_insn;

  logic        CLK;
  logic        RST_N;
  logic [31:0] INSN;
  logic        sub_sra, addr_sel, pc_next_sel, pc_alu_sel, rd_clk, mem_clk;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  alu_func;
  logic        valid, illegal_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_ill;

  decoder_r_insn dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INSN        (INSN),
    .sub_sra     (sub_sra),
    .addr_sel    (addr_sel),
    .pc_next_sel (pc_next_sel),
    .pc_alu_sel  (pc_alu_sel),
    .rd_clk      (rd_clk),
    .mem_clk     (mem_clk),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .alu_func    (alu_func),
    .valid       (valid),
    .illegal_q   (illegal_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] insn;
    logic        valid;
    logic        sub_sra;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  func;
    logic        wr;       // rd_clk expected to follow CLK
    logic        bad_op;   // OP opcode with illegal encoding
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_consts(input string name);
    check({name, " consts"}, {28'd0, addr_sel, pc_next_sel, pc_alu_sel, mem_clk}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h00F100B3, 1, 0,  2, 15,  1, 3'd0, 1, 0}; // ADD x1,x2,x15
    vecs[1]  = '{32'h402A00B3, 1, 1, 20,  2,  1, 3'd0, 1, 0}; // SUB x1,x20,x2
    vecs[2]  = '{32'h4020D0B3, 1, 1,  1,  2,  1, 3'd5, 1, 0}; // SRA x1,x1,x2
    vecs[3]  = '{32'h00208033, 1, 0,  1,  2,  0, 3'd0, 0, 0}; // ADD x0 -> no write
    vecs[4]  = '{32'h002090B3, 1, 0,  1,  2,  1, 3'd1, 1, 0}; // SLL
    vecs[5]  = '{32'h0020D0B3, 1, 0,  1,  2,  1, 3'd5, 1, 0}; // SRL
    vecs[6]  = '{32'h01DF6FB3, 1, 0, 30, 29, 31, 3'd6, 1, 0}; // OR x31,x30,x29
    vecs[7]  = '{32'h00100093, 0, 0,  0,  1,  1, 3'd0, 0, 0}; // ADDI, non-OP
    vecs[8]  = '{32'h40000013, 0, 0,  0,  0,  0, 3'd0, 0, 0}; // bit30 set, non-OP
    vecs[9]  = '{32'h402090B3, 0, 0,  1,  2,  1, 3'd1, 0, 1}; // f7 0100000 f3 001
    vecs[10] = '{32'h022080B3, 0, 0,  1,  2,  1, 3'd0, 0, 1}; // MUL (M ext)
    vecs[11] = '{32'h00F100B3, 1, 0,  2, 15,  1, 3'd0, 1, 0}; // legal again: flag sticks

    exp_ill = 1'b0;
    RST_N   = 1'b0;
    INSN    = 32'h00F100B3;

    // In reset with CLK high: gated clock and flag held low, fields still follow INSN.
    @(posedge CLK); #1;
    check("rst rd_clk", {31'd0, rd_clk}, 32'd0);
    check("rst illegal_q", {31'd0, illegal_q}, 32'd0);
    check("rst valid", {31'd0, valid}, 32'd1);
    check("rst rs1", {27'd0, rs1_addr}, 32'd2);
    check_consts("rst");

    // Release mid low phase with a non-OP instruction; flag must never set.
    @(negedge CLK);
    INSN  = 32'h00100093;
    RST_N = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      check("addi illegal_q", {31'd0, illegal_q}, 32'd0);
      check("addi rd_clk", {31'd0, rd_clk}, 32'd0);
      check("addi valid", {31'd0, valid}, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      INSN = vecs[i].insn;
      #1;
      check($sformatf("v%0d valid", i), {31'd0, valid}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d sub_sra", i), {31'd0, sub_sra}, {31'd0, vecs[i].sub_sra});
      check($sformatf("v%0d rs1", i), {27'd0, rs1_addr}, {27'd0, vecs[i].rs1});
      check($sformatf("v%0d rs2", i), {27'd0, rs2_addr}, {27'd0, vecs[i].rs2});
      check($sformatf("v%0d rd", i), {27'd0, rd_addr}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d func", i), {29'd0, alu_func}, {29'd0, vecs[i].func});
      check($sformatf("v%0d rd_clk lo", i), {31'd0, rd_clk}, 32'd0);
      check_consts($sformatf("v%0d", i));
      @(posedge CLK); #1;
      if (vecs[i].bad_op) exp_ill = 1'b1;
      check($sformatf("v%0d rd_clk hi", i), {31'd0, rd_clk}, {31'd0, vecs[i].wr});
      check($sformatf("v%0d illegal_q", i), {31'd0, illegal_q}, {31'd0, exp_ill});
    end

    // Flag is set and a writing ADD is present: async reset mid high phase.
    #1;
    RST_N = 1'b0;
    #1;
    check("midrst illegal_q", {31'd0, illegal_q}, 32'd0);
    check("midrst rd_clk", {31'd0, rd_clk}, 32'd0);

    // Release coincident with a rising edge while an illegal encoding is present.
    @(negedge CLK);
    INSN = 32'h402090B3;
    @(posedge CLK);
    // Scheduled after the flop has evaluated this edge, modelling the coincident release.
    RST_N <= 1'b1;
    #1;
    check("release edge illegal_q", {31'd0, illegal_q}, 32'd0);
    @(posedge CLK); #1;
    check("next edge illegal_q", {31'd0, illegal_q}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
